// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared state encodings, sweep-direction constants and
//                request-vector search helpers for the elevator controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Widest request vector the helpers accept (upper bound on floors)
    localparam int MAX_FLOORS = 32;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_MOVE_UP   = 3'd1;
    localparam state_t ST_MOVE_DOWN = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_DOOR_OPEN = 3'd4;
    localparam state_t ST_OFF       = 3'd5;

    // Sweep direction values
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when any request bit sits strictly above floor pos
    function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec,
                                       input logic [31:0]           pos);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ((32'(i) > pos) && vec[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when any request bit sits strictly below floor pos
    function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec,
                                       input logic [31:0]           pos);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ((32'(i) < pos) && vec[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_climate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_climate_ctrl
//  Description : Cabin cooler/heater hysteresis comparators. Registered
//                outputs, forced off while disabled; cooler has priority if
//                the thresholds overlap.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_climate_ctrl #(
    parameter int TEMP_W    = 32,
    parameter int TEMP_LOW  = 18,
    parameter int TEMP_HIGH = 26,
    parameter int HYST      = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [TEMP_W-1:0] temp,
    output logic                     cooler,
    output logic                     heater
);

    localparam logic signed [TEMP_W-1:0] c_cool_on  = TEMP_W'(TEMP_HIGH);
    localparam logic signed [TEMP_W-1:0] c_cool_off = TEMP_W'(TEMP_HIGH - HYST);
    localparam logic signed [TEMP_W-1:0] c_heat_on  = TEMP_W'(TEMP_LOW);
    localparam logic signed [TEMP_W-1:0] c_heat_off = TEMP_W'(TEMP_LOW + HYST);

    logic r_cooler;
    logic r_heater;
    logic w_cool_nxt;
    logic w_heat_nxt;

    // Hysteresis decisions; between thresholds each output holds its value
    always_comb begin
        w_cool_nxt = r_cooler;
        w_heat_nxt = r_heater;
        if (temp > c_cool_on) begin
            w_cool_nxt = 1'b1;
        end else if (temp <= c_cool_off) begin
            w_cool_nxt = 1'b0;
        end
        if (temp < c_heat_on) begin
            w_heat_nxt = 1'b1;
        end else if (temp >= c_heat_off) begin
            w_heat_nxt = 1'b0;
        end
        if (w_cool_nxt) w_heat_nxt = 1'b0;
        if (!enable) begin
            w_cool_nxt = 1'b0;
            w_heat_nxt = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cooler <= 1'b0;
            r_heater <= 1'b0;
        end else begin
            r_cooler <= w_cool_nxt;
            r_heater <= w_heat_nxt;
        end
    end

    assign cooler = r_cooler;
    assign heater = r_heater;

endmodule
`default_nettype wire

// File: rtl/elevator_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_multi_ctrl
//  Description : SCAN-scheduled elevator controller with latched cabin/hall
//                requests, timed door, draining off mode and cabin climate.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_multi_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES = 16,
    parameter int TEMP_W      = 32,
    parameter int TEMP_HIGH   = 26,
    parameter int TEMP_LOW    = 18,
    parameter int HYST        = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     off_btn,
    input  logic [FLOOR_W-1:0]       position,
    input  logic [NUM_FLOORS-1:0]    cabin_press,
    input  logic [NUM_FLOORS-1:0]    call_up,
    input  logic [NUM_FLOORS-1:0]    call_down,
    input  logic signed [TEMP_W-1:0] temp,
    output logic                     door,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic                     cooler,
    output logic                     heater,
    output logic [NUM_FLOORS-1:0]    pending,
    output logic                     dir_up
);

    localparam int                    c_timer_w   = $clog2(DOOR_CYCLES + 1);
    localparam logic [c_timer_w-1:0]  c_door_load = c_timer_w'(DOOR_CYCLES);
    localparam logic [c_timer_w-1:0]  c_timer_one = c_timer_w'(1);
    localparam logic [31:0]           c_floor_cnt = 32'(NUM_FLOORS);
    localparam logic [31:0]           c_top_floor = 32'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] c_one       = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    state_t                  w_idle_state;
    logic                    r_dir_up;
    logic                    w_dir_nxt;
    logic                    w_idle_dir;
    logic [NUM_FLOORS-1:0]   r_req_cab;
    logic [NUM_FLOORS-1:0]   r_req_up;
    logic [NUM_FLOORS-1:0]   r_req_dn;
    logic [NUM_FLOORS-1:0]   w_req_cab_nxt;
    logic [NUM_FLOORS-1:0]   w_req_up_nxt;
    logic [NUM_FLOORS-1:0]   w_req_dn_nxt;
    logic [NUM_FLOORS-1:0]   w_press_all;
    logic [NUM_FLOORS-1:0]   w_req_eff;
    logic [NUM_FLOORS-1:0]   w_pos_bit;
    logic [NUM_FLOORS-1:0]   w_clr_mask;
    logic [c_timer_w-1:0]    r_timer;
    logic                    r_shutdown;
    logic                    r_fault;
    logic [FLOOR_W-1:0]      r_off_pos;
    logic                    r_door;
    logic                    r_motor_up;
    logic                    r_motor_down;
    logic                    r_dir_out;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [31:0]             w_pos_ext;
    logic                    w_pos_valid;
    logic                    w_press_en;
    logic                    w_flush;
    logic                    w_at_pos;
    logic                    w_above;
    logic                    w_below;
    logic                    w_door_press;
    logic                    w_moving;
    logic                    w_climate_en;

    // Floor decode and request views; an out-of-range floor matches nothing
    assign w_pos_ext    = 32'(position);
    assign w_pos_valid  = (w_pos_ext < c_floor_cnt);
    assign w_pos_bit    = w_pos_valid ? (c_one << position) : '0;
    assign w_press_en   = !off_btn && (r_state != ST_OFF);
    assign w_flush      = off_btn || (r_state == ST_OFF);
    assign w_press_all  = cabin_press | call_up | call_down;
    // Decisions see this cycle's presses too, so a press acts on the next edge
    assign w_req_eff    = w_press_en ? (r_req_cab | r_req_up | r_req_dn | w_press_all) : '0;
    assign w_at_pos     = |(w_req_eff & w_pos_bit);
    assign w_above      = w_pos_valid && any_above(MAX_FLOORS'(w_req_eff), w_pos_ext);
    assign w_below      = w_pos_valid && any_below(MAX_FLOORS'(w_req_eff), w_pos_ext);
    assign w_door_press = w_press_en && |(w_press_all & w_pos_bit);
    assign w_moving     = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign w_climate_en = (w_state_nxt != ST_OFF);

    // Idle dispatch: serve here, else keep sweeping in dir_up when possible
    always_comb begin
        w_idle_state = ST_IDLE;
        w_idle_dir   = r_dir_up;
        if (w_at_pos) begin
            w_idle_state = ST_DOOR_OPEN;
        end else if (w_above && (r_dir_up || !w_below)) begin
            w_idle_state = ST_MOVE_UP;
            w_idle_dir   = DIR_UP;
        end else if (w_below) begin
            w_idle_state = ST_MOVE_DOWN;
            w_idle_dir   = DIR_DOWN;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_up;
        case (r_state)
            ST_IDLE: begin
                if (off_btn) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_state_nxt = w_idle_state;
                    w_dir_nxt   = w_idle_dir;
                end
            end
            ST_MOVE_UP: begin
                if (!w_pos_valid || w_at_pos || (w_pos_ext == c_top_floor) ||
                    (r_shutdown && (position != r_off_pos))) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_MOVE_DOWN: begin
                if (!w_pos_valid || w_at_pos || (w_pos_ext == 32'd0) ||
                    (r_shutdown && (position != r_off_pos))) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                w_state_nxt = r_fault ? ST_IDLE : ST_DOOR_OPEN;
            end
            ST_DOOR_OPEN: begin
                if (!w_door_press && (r_timer <= c_timer_one)) begin
                    if (off_btn || r_shutdown) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_state_nxt = w_idle_state;
                        w_dir_nxt   = w_idle_dir;
                    end
                end
            end
            ST_OFF: begin
                if (!off_btn) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Requests at the door floor are dropped on entry and while the door is open
    assign w_clr_mask    = ((w_state_nxt == ST_DOOR_OPEN) || (r_state == ST_DOOR_OPEN)) ?
                           w_pos_bit : '0;
    assign w_req_cab_nxt = w_flush ? '0 : ((r_req_cab | cabin_press) & ~w_clr_mask);
    assign w_req_up_nxt  = w_flush ? '0 : ((r_req_up  | call_up)     & ~w_clr_mask);
    assign w_req_dn_nxt  = w_flush ? '0 : ((r_req_dn  | call_down)   & ~w_clr_mask);

    // State, request latches and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_dir_up     <= DIR_UP;
            r_dir_out    <= DIR_UP;
            r_req_cab    <= '0;
            r_req_up     <= '0;
            r_req_dn     <= '0;
            r_pending    <= '0;
            r_door       <= 1'b0;
            r_motor_up   <= 1'b0;
            r_motor_down <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dir_up     <= w_dir_nxt;
            r_dir_out    <= w_dir_nxt && (w_state_nxt != ST_OFF);
            r_req_cab    <= w_req_cab_nxt;
            r_req_up     <= w_req_up_nxt;
            r_req_dn     <= w_req_dn_nxt;
            r_pending    <= w_req_cab_nxt | w_req_up_nxt | w_req_dn_nxt;
            r_door       <= (w_state_nxt == ST_DOOR_OPEN);
            r_motor_up   <= (w_state_nxt == ST_MOVE_UP);
            r_motor_down <= (w_state_nxt == ST_MOVE_DOWN);
        end
    end

    // Door timer, shutdown drain tracking and bad-position fault flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer    <= '0;
            r_shutdown <= 1'b0;
            r_off_pos  <= '0;
            r_fault    <= 1'b0;
        end else begin
            if ((w_state_nxt == ST_DOOR_OPEN) &&
                ((r_state != ST_DOOR_OPEN) || w_door_press)) begin
                r_timer <= c_door_load;
            end else if ((r_state == ST_DOOR_OPEN) && (r_timer != '0)) begin
                r_timer <= r_timer - c_timer_one;
            end

            if ((w_state_nxt == ST_OFF) || (w_state_nxt == ST_IDLE)) begin
                r_shutdown <= 1'b0;
            end else if (w_moving && off_btn && !r_shutdown) begin
                r_shutdown <= 1'b1;
                r_off_pos  <= position;
            end

            if (w_moving && !w_pos_valid) begin
                r_fault <= 1'b1;
            end else if (r_state == ST_STOP) begin
                r_fault <= 1'b0;
            end
        end
    end

    elevator_climate_ctrl #(
        .TEMP_W    (TEMP_W),
        .TEMP_LOW  (TEMP_LOW),
        .TEMP_HIGH (TEMP_HIGH),
        .HYST      (HYST)
    ) u_climate (
        .clock  (clock),
        .reset  (reset),
        .enable (w_climate_en),
        .temp   (temp),
        .cooler (cooler),
        .heater (heater)
    );

    assign door       = r_door;
    assign motor_up   = r_motor_up;
    assign motor_down = r_motor_down;
    assign pending    = r_pending;
    assign dir_up     = r_dir_out;

endmodule
`default_nettype wire

// File: tb/tb_elevator_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_multi_ctrl
//  Description : Directed self-checking bench for elevator_multi_ctrl
//                (8 floors, 4-cycle door).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_multi_ctrl;

    logic               clock;
    logic               reset;
    logic               off_btn;
    logic [2:0]         position;
    logic [7:0]         cabin_press;
    logic [7:0]         call_up;
    logic [7:0]         call_down;
    logic signed [31:0] temp;
    logic               door;
    logic               motor_up;
    logic               motor_down;
    logic               cooler;
    logic               heater;
    logic [7:0]         pending;
    logic               dir_up;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_multi_ctrl #(
        .NUM_FLOORS  (8),
        .DOOR_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .off_btn     (off_btn),
        .position    (position),
        .cabin_press (cabin_press),
        .call_up     (call_up),
        .call_down   (call_down),
        .temp        (temp),
        .door        (door),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .cooler      (cooler),
        .heater      (heater),
        .pending     (pending),
        .dir_up      (dir_up)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_checks++; if ({door, motor_up, motor_down} !== 3'b000) begin n_fail++; $display("FAIL reset_drive: got %b expected 000", {door, motor_up, motor_down}); end
        n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h expected 00", pending); end
        n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b expected 1", dir_up); end
        n_checks++; if ({cooler, heater} !== 2'b00) begin n_fail++; $display("FAIL reset_climate: got %b expected 00", {cooler, heater}); end
        reset = 1'b1;
    endtask

    task automatic test_single_trip();
        int hi;
        position    = 3'd1;
        cabin_press = 8'h04;
        step();
        cabin_press = 8'h00;
        n_checks++; if ({motor_up, motor_down} !== 2'b10) begin n_fail++; $display("FAIL trip_motor: got %b expected 10", {motor_up, motor_down}); end
        n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL trip_pending: got %h expected 04", pending); end
        position = 3'd2;
        step();
        n_checks++; if ({motor_up, motor_down, door} !== 3'b000) begin n_fail++; $display("FAIL trip_stop: got %b expected 000", {motor_up, motor_down, door}); end
        step();
        n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL trip_clear: got %h expected 00", pending); end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (door === 1'b1) hi++;
            if (i < 3) step();
        end
        n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL trip_door_len: got %0d expected 4", hi); end
        step();
        n_checks++; if ({door, motor_up, motor_down} !== 3'b000) begin n_fail++; $display("FAIL trip_door_close: got %b expected 000", {door, motor_up, motor_down}); end
    endtask

    task automatic test_scan();
        int hi;
        position  = 3'd3;
        call_up   = 8'h40;
        call_down = 8'h02;
        step();
        call_up   = 8'h00;
        call_down = 8'h00;
        n_checks++; if ({motor_up, dir_up} !== 2'b11) begin n_fail++; $display("FAIL scan_up_first: got %b expected 11", {motor_up, dir_up}); end
        n_checks++; if (pending !== 8'h42) begin n_fail++; $display("FAIL scan_pending: got %h expected 42", pending); end
        for (int p = 4; p <= 6; p++) begin
            position = 3'(p);
            step();
        end
        n_checks++; if ({motor_up, door} !== 2'b00) begin n_fail++; $display("FAIL scan_stop6: got %b expected 00", {motor_up, door}); end
        step();
        n_checks++; if ({door, pending} !== {1'b1, 8'h02}) begin n_fail++; $display("FAIL scan_serve6: got %h expected 102", {door, pending}); end
        repeat (4) step();
        n_checks++; if ({door, motor_down, dir_up} !== 3'b010) begin n_fail++; $display("FAIL scan_reverse: got %b expected 010", {door, motor_down, dir_up}); end
        for (int p = 5; p >= 1; p--) begin
            position = 3'(p);
            step();
        end
        step();
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (door === 1'b1) hi++;
            step();
        end
        n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL scan_door1: got %0d expected 4", hi); end
        n_checks++; if ({pending, door, motor_up, motor_down} !== 11'd0) begin n_fail++; $display("FAIL scan_done: got %h expected 000", {pending, door, motor_up, motor_down}); end
    endtask

    task automatic test_door_restart();
        int hi;
        position = 3'd4;
        step();
        cabin_press = 8'h10;
        step();
        cabin_press = 8'h00;
        n_checks++; if ({door, pending} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL door_open4: got %h expected 100", {door, pending}); end
        step();
        step();
        cabin_press = 8'h10;
        step();
        cabin_press = 8'h00;
        n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL door_press_latched: got %h expected 00", pending); end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (door === 1'b1) hi++;
            if (i < 3) step();
        end
        n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL door_restart_len: got %0d expected 4", hi); end
        step();
        n_checks++; if (door !== 1'b0) begin n_fail++; $display("FAIL door_restart_close: got %b expected 0", door); end
    endtask

    task automatic test_off_moving();
        position = 3'd5;
        step();
        cabin_press = 8'h01;
        step();
        cabin_press = 8'h00;
        n_checks++; if ({motor_down, dir_up} !== 2'b10) begin n_fail++; $display("FAIL off_start_down: got %b expected 10", {motor_down, dir_up}); end
        position = 3'd4;
        step();
        off_btn     = 1'b1;
        cabin_press = 8'h40;
        step();
        cabin_press = 8'h00;
        n_checks++; if ({pending, motor_down} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL off_drain: got %h expected 001", {pending, motor_down}); end
        position = 3'd3;
        step();
        n_checks++; if ({motor_down, door} !== 2'b00) begin n_fail++; $display("FAIL off_stop3: got %b expected 00", {motor_down, door}); end
        step();
        n_checks++; if (door !== 1'b1) begin n_fail++; $display("FAIL off_door: got %b expected 1", door); end
        repeat (4) step();
        temp        = 32'sd30;
        cabin_press = 8'h04;
        step();
        cabin_press = 8'h00;
        n_checks++; if ({door, motor_up, motor_down, cooler, heater, dir_up, pending} !== 14'd0) begin n_fail++; $display("FAIL off_all_zero: got %h expected 0000", {door, motor_up, motor_down, cooler, heater, dir_up, pending}); end
        off_btn = 1'b0;
        step();
        n_checks++; if ({cooler, pending, door} !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL off_resume: got %h expected 200", {cooler, pending, door}); end
        temp = 32'sd20;
        step();
    endtask

    task automatic test_climate();
        logic signed [31:0] t_vec [9];
        logic [1:0]         e_vec [9];
        t_vec = '{32'sd20, 32'sd26, 32'sd27, 32'sd25, 32'sd24, 32'sd18, 32'sd17, 32'sd19, 32'sd20};
        e_vec = '{2'b00,   2'b00,   2'b10,   2'b10,   2'b00,   2'b00,   2'b01,   2'b01,   2'b00};
        for (int i = 0; i < 9; i++) begin
            temp = t_vec[i];
            step();
            n_checks++; if ({cooler, heater} !== e_vec[i]) begin n_fail++; $display("FAIL climate_%0d: temp %0d got %b expected %b", i, t_vec[i], {cooler, heater}, e_vec[i]); end
        end
    endtask

    task automatic test_async_reset();
        position    = 3'd2;
        cabin_press = 8'h20;
        step();
        cabin_press = 8'h00;
        n_checks++; if (motor_up !== 1'b1) begin n_fail++; $display("FAIL areset_moving: got %b expected 1", motor_up); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if ({motor_up, pending} !== 9'd0) begin n_fail++; $display("FAIL areset_drop: got %h expected 000", {motor_up, pending}); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
        n_checks++; if ({door, motor_up, motor_down, dir_up, pending} !== {4'b0001, 8'h00}) begin n_fail++; $display("FAIL areset_idle: got %h expected 100", {door, motor_up, motor_down, dir_up, pending}); end
        cabin_press = 8'h04;
        step();
        cabin_press = 8'h00;
        n_checks++; if (door !== 1'b1) begin n_fail++; $display("FAIL areset_serve: got %b expected 1", door); end
    endtask

    initial begin
        reset       = 1'b0;
        off_btn     = 1'b0;
        position    = 3'd0;
        cabin_press = 8'h00;
        call_up     = 8'h00;
        call_down   = 8'h00;
        temp        = 32'sd20;
        test_reset();
        test_single_trip();
        test_scan();
        test_door_restart();
        test_off_moving();
        test_climate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_multi_ctrl.md
Name: elevator_multi_ctrl

Overview:
Parametrised next-generation elevator controller: NUM_FLOORS floors, one-hot cabin and hall-call request vectors latched into a pending set, and SCAN (sweep) scheduling. It adds a timed door, an off mode that drains safely, and cabin climate control with hysteresis. It sits between the floor/cabin button decoders and position sensor on one side and the motor, door and HVAC drivers on the other.

Parameters:
NUM_FLOORS, 8, number of floors (2..32)
FLOOR_W, $clog2(NUM_FLOORS), width of floor index
DOOR_CYCLES, 16, clocks door stays open after a stop (>=2)
TEMP_W, 32, signed temperature width
TEMP_HIGH, 26, cooler turn-on threshold (strictly greater than)
TEMP_LOW, 18, heater turn-on threshold (strictly less than)
HYST, 2, hysteresis band for climate turn-off

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
off_btn  in  1  level; high requests shutdown
position  in  FLOOR_W  current floor from sensor, sampled each clock
cabin_press  in  NUM_FLOORS  one-cycle pulses, bit f = cabin button f
call_up  in  NUM_FLOORS  hall up-call pulses
call_down  in  NUM_FLOORS  hall down-call pulses
temp  in  TEMP_W signed  cabin temperature
door  out  1  door open
motor_up  out  1  drive up
motor_down  out  1  drive down
cooler  out  1  cooler on
heater  out  1  heater on
pending  out  NUM_FLOORS  OR of latched cabin/up/down requests per floor
dir_up  out  1  current sweep direction (1 = up)

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0, pending 0, dir_up 1, door timer 0.
- All outputs registered; every decision below acts on the next rising edge.
- Request latch: each clock, req_cab |= cabin_press, req_up |= call_up, req_dn |= call_down, except when off_btn=1 or state OFF (presses ignored). Bits with index >= NUM_FLOORS do not exist.
- States: IDLE, MOVE_UP, MOVE_DOWN, STOP, DOOR_OPEN, OFF.
- IDLE: if off_btn -> OFF. Else if any request at position -> DOOR_OPEN. Else if any request above -> MOVE_UP, dir_up=1. Else if any request below -> MOVE_DOWN, dir_up=0. Else stay. If requests exist both above and below, the current dir_up wins.
- MOVE_UP/MOVE_DOWN: motor_up or motor_down=1 respectively. When a pending request is at position, or position is NUM_FLOORS-1 (up) or 0 (down) -> STOP. Both motors are never 1 together.
- STOP: motors 0 for exactly one cycle -> DOOR_OPEN.
- DOOR_OPEN: door=1; timer loads DOOR_CYCLES on entry and counts down; all three request bits at position clear on entry. A press/call at position while door open restarts the timer and is not latched. Timer reaches 0 -> door=0 -> OFF if off_btn, else apply the IDLE decision rules that same cycle, preferring to continue in dir_up.
- off_btn while moving: all pending requests clear immediately; the car continues to the next floor change, stops (STOP, DOOR_OPEN), then enters OFF.
- OFF: all outputs 0 including cooler/heater; off_btn=0 -> IDLE.
- Climate (not in OFF): cooler sets when temp > TEMP_HIGH and clears when temp <= TEMP_HIGH-HYST. Heater sets when temp < TEMP_LOW and clears when temp >= TEMP_LOW+HYST. Comparisons are signed. Heater and cooler are never both 1; if thresholds are misconfigured, cooler wins.
- Out-of-range position (>= NUM_FLOORS): treated as no request match. While moving, -> STOP then IDLE, with the door kept closed.
- Reset mid-motion: motors drop asynchronously and all requests are lost.

Decomposition:
- Package elevator_pkg holds the state enum (6 states), direction constants DIR_UP/DIR_DOWN, and helper functions any_above(vec, pos) and any_below(vec, pos).
- Sub-module elevator_climate_ctrl: hysteresis comparator pair with parameters TEMP_W, TEMP_LOW, TEMP_HIGH, HYST and an enable input driven low in OFF.

Test Plan:
1. Defaults with DOOR_CYCLES=4; reset low for 5 clocks, release, position=1, cabin_press[2] pulse -> motor_up=1 next cycle; drive position=2 -> STOP (motors 0 for 1 cycle), door=1 for 4 cycles, pending[2] cleared.
2. position=3 idle; call_up[6] and call_down[1] in the same cycle -> goes up first (dir_up=1), serves 6, then reverses and serves 1; pending=0 at end.
3. Door open at floor 4; cabin_press[4] on the 3rd door cycle -> door stays 1 for 4 more cycles; pending[4] stays 0.
4. Moving down from 5 toward 0 with pending[0]; off_btn=1 at position=4 -> pending cleared, stops at the next floor (3), door cycles, enters OFF; all outputs 0; presses ignored until off_btn=0.
5. temp ramps 20->27->25->24 -> cooler 0,1,1,0; temp 17 -> heater 1; temp 19 -> heater stays 1; temp 20 -> heater 0; never both high.
6. Reset low asserted mid-MOVE_UP -> motor_up=0 within the same cycle (async); after release, state IDLE and pending=0.
